// File: rtl/video_timing_gen.sv
// Raster timing generator with a placeable picture window: issues buffer read
// coordinates, then realigns returned pixels with hs/vs/de after READ_LAT cycles.
module video_timing_gen #(
  parameter int          H_ACTIVE     = 1920,
  parameter int          H_FP         = 88,
  parameter int          H_SYNC       = 44,
  parameter int          H_BP         = 148,
  parameter int          V_ACTIVE     = 1080,
  parameter int          V_FP         = 4,
  parameter int          V_SYNC       = 5,
  parameter int          V_BP         = 36,
  parameter bit          HS_POL       = 1'b1,
  parameter bit          VS_POL       = 1'b1,
  parameter int          PIC_X0       = 0,
  parameter int          PIC_Y0       = 0,
  parameter int          PIC_W        = 1920,
  parameter int          PIC_H        = 1080,
  parameter int          READ_LAT     = 2,
  parameter int          PIX_MODE     = 0,
  parameter logic [23:0] BORDER_COLOR = 24'h000000
) (
  input  logic        video_clk,
  input  logic        rst_n,
  input  logic [23:0] read_data,
  output logic        pic_rd_en,
  output logic [11:0] pic_x,
  output logic [11:0] pic_y,
  output logic        hs,
  output logic        vs,
  output logic        de,
  output logic [23:0] vout_data,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [31:0] H_LAST = 32'(H_TOTAL - 1);
  localparam logic [31:0] V_LAST = 32'(V_TOTAL - 1);
  localparam logic [31:0] H_ACT  = 32'(H_ACTIVE);
  localparam logic [31:0] V_ACT  = 32'(V_ACTIVE);
  localparam logic [31:0] HS_LO  = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] HS_HI  = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] VS_LO  = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] VS_HI  = 32'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [31:0] X_LO   = 32'(PIC_X0);
  localparam logic [31:0] X_HI   = 32'(PIC_X0 + PIC_W);
  localparam logic [31:0] Y_LO   = 32'(PIC_Y0);
  localparam logic [31:0] Y_HI   = 32'(PIC_Y0 + PIC_H);

  // Timing tap layout: {first, in_win, de, vs, hs}; idle keeps syncs inactive.
  localparam logic [4:0] TAP_IDLE = {3'b000, ~VS_POL, ~HS_POL};

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic [4:0]    s0_q, s0_d;
  logic [11:0]   pic_x_q, pic_x_d, pic_y_q, pic_y_d;
  logic [31:0]   h_ext, v_ext;
  logic          active, in_win, h_wrap, v_wrap;

  always_comb begin
    h_ext   = 32'(h_cnt_q);
    v_ext   = 32'(v_cnt_q);
    h_wrap  = (h_ext == H_LAST);
    v_wrap  = (v_ext == V_LAST);
    h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_wrap) begin
      v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
    end
    active = (h_ext < H_ACT) && (v_ext < V_ACT);
    // Bounding by the active area clips an oversize window instead of wrapping it.
    in_win = active && (h_ext >= X_LO) && (h_ext < X_HI)
                    && (v_ext >= Y_LO) && (v_ext < Y_HI);
    s0_d = {(h_ext == 32'd0) && (v_ext == 32'd0), in_win, active,
            ((v_ext >= VS_LO) && (v_ext < VS_HI)) ? VS_POL : ~VS_POL,
            ((h_ext >= HS_LO) && (h_ext < HS_HI)) ? HS_POL : ~HS_POL};
    pic_x_d = in_win ? 12'(h_ext - X_LO) : 12'd0;
    pic_y_d = in_win ? 12'(v_ext - Y_LO) : 12'd0;
  end

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      s0_q    <= TAP_IDLE;
      pic_x_q <= '0;
      pic_y_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      s0_q    <= s0_d;
      pic_x_q <= pic_x_d;
      pic_y_q <= pic_y_d;
    end
  end

  genvar gi;
  for (gi = 0; gi < READ_LAT; gi++) begin : g_stg
    logic [4:0] tap_q;
    if (gi == 0) begin : g_head
      always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) tap_q <= TAP_IDLE;
        else        tap_q <= s0_q;
      end
    end else begin : g_body
      always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) tap_q <= TAP_IDLE;
        else        tap_q <= g_stg[gi-1].tap_q;
      end
    end
  end

  logic [4:0]  tap;
  logic [23:0] rgb565, data_d, data_q;
  logic        hs_q, vs_q, de_q, fs_q;

  always_comb begin
    tap    = g_stg[READ_LAT-1].tap_q;
    rgb565 = {read_data[15:11], read_data[15:13],
              read_data[10:5],  read_data[10:9],
              read_data[4:0],   read_data[4:2]};
    data_d = 24'h000000;
    if (tap[3]) begin
      data_d = (PIX_MODE == 1) ? read_data : rgb565;
    end else if (tap[2]) begin
      data_d = BORDER_COLOR;
    end
  end

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q   <= ~HS_POL;
      vs_q   <= ~VS_POL;
      de_q   <= 1'b0;
      fs_q   <= 1'b0;
      data_q <= '0;
    end else begin
      hs_q   <= tap[0];
      vs_q   <= tap[1];
      de_q   <= tap[2];
      fs_q   <= tap[4];
      data_q <= data_d;
    end
  end

  assign pic_rd_en   = s0_q[3];
  assign pic_x       = pic_x_q;
  assign pic_y       = pic_y_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign de          = de_q;
  assign frame_start = fs_q;
  assign vout_data   = data_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Four small-raster instances (normal, RGB565 + low syncs, clipped window,
// empty window) compared every cycle against a raster-position reference model.
module tb_video_timing_gen;
  localparam int NI = 4;
  localparam int HA = 8, HFP = 2, HSY = 2, HBP = 2, HT = HA + HFP + HSY + HBP;
  localparam int VA = 4, VFP = 1, VSY = 1, VBP = 1, VT = VA + VFP + VSY + VBP;
  localparam int LAT = 2;

  localparam int          CX0[NI]  = '{2, 2, 6, 2};
  localparam int          CY0[NI]  = '{1, 1, 1, 1};
  localparam int          CW[NI]   = '{4, 4, 4, 0};
  localparam int          CH[NI]   = '{2, 2, 2, 2};
  localparam bit          HP[NI]   = '{1'b1, 1'b0, 1'b1, 1'b1};
  localparam bit          VP[NI]   = '{1'b1, 1'b0, 1'b1, 1'b0};
  localparam int          MODE[NI] = '{1, 0, 1, 1};
  localparam logic [23:0] BRD[NI]  = '{24'h123456, 24'hA5A5A5, 24'h0000FF, 24'hC0FFEE};

  logic        video_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] rdata [NI];
  logic        rd_w [NI];
  logic [11:0] px_w [NI];
  logic [11:0] py_w [NI];
  logic        hs_w [NI];
  logic        vs_w [NI];
  logic        de_w [NI];
  logic        fs_w [NI];
  logic [23:0] vo_w [NI];

  always #5 video_clk = ~video_clk;

  genvar gi;
  for (gi = 0; gi < NI; gi++) begin : g_dut
    video_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
      .HS_POL(HP[gi]), .VS_POL(VP[gi]),
      .PIC_X0(CX0[gi]), .PIC_Y0(CY0[gi]), .PIC_W(CW[gi]), .PIC_H(CH[gi]),
      .READ_LAT(LAT), .PIX_MODE(MODE[gi]), .BORDER_COLOR(BRD[gi])
    ) u_dut (
      .video_clk  (video_clk),
      .rst_n      (rst_n),
      .read_data  (rdata[gi]),
      .pic_rd_en  (rd_w[gi]),
      .pic_x      (px_w[gi]),
      .pic_y      (py_w[gi]),
      .hs         (hs_w[gi]),
      .vs         (vs_w[gi]),
      .de         (de_w[gi]),
      .vout_data  (vo_w[gi]),
      .frame_start(fs_w[gi])
    );
  end

  typedef struct packed {
    logic        rd;
    logic [11:0] x;
    logic [11:0] y;
    logic        hs;
    logic        vs;
    logic        de;
    logic        fs;
    logic [23:0] d;
  } exp_t;

  int          k;            // clock edges since reset release
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [24:0] req_q [NI][1024];
  logic [23:0] hist  [NI][1024];

  function automatic logic [23:0] c565(logic [15:0] p);
    return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
  endfunction

  function automatic logic in_window(int i, int h, int v);
    return (h < HA) && (v < VA) && (h >= CX0[i]) && (h < CX0[i] + CW[i])
        && (v >= CY0[i]) && (v < CY0[i] + CH[i]);
  endfunction

  // Request side shows raster position k-1; the output side lags LAT+1 more.
  function automatic exp_t model(int i, int kk);
    exp_t e;
    int   p, h, v;
    e    = '0;
    e.hs = ~HP[i];
    e.vs = ~VP[i];
    p = kk - 1;
    if (p >= 0) begin
      h = p % HT;
      v = (p / HT) % VT;
      if (in_window(i, h, v)) begin
        e.rd = 1'b1;
        e.x  = 12'(h - CX0[i]);
        e.y  = 12'(v - CY0[i]);
      end
    end
    p = kk - 2 - LAT;
    if (p >= 0) begin
      h = p % HT;
      v = (p / HT) % VT;
      e.de = (h < HA) && (v < VA);
      e.hs = (h >= HA + HFP && h < HA + HFP + HSY) ? HP[i] : ~HP[i];
      e.vs = (v >= VA + VFP && v < VA + VFP + VSY) ? VP[i] : ~VP[i];
      e.fs = (h == 0) && (v == 0);
      if (in_window(i, h, v))
        e.d = (MODE[i] == 1) ? {12'(v - CY0[i]), 12'(h - CX0[i])} : c565(hist[i][kk][15:0]);
      else if (e.de)
        e.d = BRD[i];
    end
    return e;
  endfunction

  task automatic chk(string tag, int i, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s[%0d] k=%0d got=%0h exp=%0h", tag, i, k, obs, exp);
    end
  endtask

  task automatic check_all();
    exp_t e;
    for (int i = 0; i < NI; i++) begin
      e = model(i, k);
      chk("pic_rd_en", i, 32'(rd_w[i]), 32'(e.rd));
      chk("pic_x", i, 32'(px_w[i]), 32'(e.x));
      chk("pic_y", i, 32'(py_w[i]), 32'(e.y));
      chk("hs", i, 32'(hs_w[i]), 32'(e.hs));
      chk("vs", i, 32'(vs_w[i]), 32'(e.vs));
      chk("de", i, 32'(de_w[i]), 32'(e.de));
      chk("frame_start", i, 32'(fs_w[i]), 32'(e.fs));
      chk("vout_data", i, 32'(vo_w[i]), 32'(e.d));
    end
  endtask

  // Buffer model: window requests are answered LAT cycles later, anything else is noise.
  task automatic drive();
    logic [23:0] val;
    for (int i = 0; i < NI; i++) begin
      req_q[i][k] = {rd_w[i], py_w[i], px_w[i]};
      val = 24'($urandom);
      if (MODE[i] == 1) begin
        if (k > LAT && req_q[i][k-LAT][24]) val = req_q[i][k-LAT][23:0];
      end else begin
        case ($urandom_range(0, 2))
          0:       val = {8'($urandom), 16'hF81F};
          1:       val = {8'($urandom), 16'h07E0};
          default: val = 24'($urandom);
        endcase
      end
      rdata[i] = val;
      hist[i][k+1] = val;
    end
  endtask

  task automatic tick();
    @(posedge video_clk);
    if (rst_n) k++;
    #1;
    check_all();
    drive();
  endtask

  task automatic reset_pulse(int cycles);
    #1 rst_n = 1'b0;
    k = 0;
    #1 check_all();
    drive();
    repeat (cycles) tick();
    #3 rst_n = 1'b1;
  endtask

  initial begin
    int r;
    k = 0;
    drive();
    repeat (3) tick();
    #3 rst_n = 1'b1;
    // three full frames, then stop with the counters at (5,2)
    while (k < 3 * HT * VT + 2 * HT + 5) tick();
    reset_pulse(3);
    while (k < 130) tick();
    r = int'($urandom_range(1, 97));
    while (k < 130 + r) tick();
    reset_pulse(int'($urandom_range(1, 4)));
    while (k < 2 * HT * VT + 10) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised successor to the fixed-resolution video timing/alignment stage in the picture transmit path.
- Runs in the video_clk domain and generates hs/vs/de raster timing.
- Issues picture-buffer read coordinates for a placeable picture window, then realigns the returned pixel data with the delayed timing.
- Adds configurable read latency, RGB565/RGB888 input formats, a border colour and a frame-start strobe.

Parameters:
- H_ACTIVE, 1920: active pixels per line
- H_FP, 88: horizontal front porch
- H_SYNC, 44: hsync width
- H_BP, 148: horizontal back porch
- V_ACTIVE, 1080: active lines
- V_FP, 4: vertical front porch
- V_SYNC, 5: vsync width
- V_BP, 36: vertical back porch
- HS_POL, 1: hs active level
- VS_POL, 1: vs active level
- PIC_X0, 0: window left edge in active area
- PIC_Y0, 0: window top edge in active area
- PIC_W, 1920: window width
- PIC_H, 1080: window height
- READ_LAT, 2: cycles from pic_rd_en to valid read_data (1..8)
- PIX_MODE, 0: 0 = RGB565 in read_data[15:0]; 1 = RGB888 in read_data[23:0]
- BORDER_COLOR, 24'h000000: RGB888 colour for active pixels outside the window

Ports:
- video_clk, input, 1: pixel clock
- rst_n, input, 1: asynchronous active-low reset
- read_data, input, 24: pixel returned from the picture buffer
- pic_rd_en, output, 1: buffer read request for the current window pixel
- pic_x, output, 12: window-relative column
- pic_y, output, 12: window-relative row
- hs, output, 1: horizontal sync, aligned with vout_data
- vs, output, 1: vertical sync, aligned with vout_data
- de, output, 1: data enable, aligned with vout_data
- vout_data, output, 24: RGB888 {R,G,B}
- frame_start, output, 1: one-cycle pulse coincident with output pixel (0,0)

Behaviour:
- Counters:
  - H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP; V_TOTAL defined likewise.
  - h_cnt counts 0..H_TOTAL-1 and wraps to 0. v_cnt increments on each h wrap and wraps after V_TOTAL-1.
  - Region order per line/frame: active, front porch, sync, back porch.
  - Active: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
  - Sync: H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; vertical sync uses the same rule on v_cnt.
- Stage 0 (registered from the counters):
  - raw hs/vs/de.
  - in_win = active and PIC_X0 <= h_cnt < PIC_X0+PIC_W and PIC_Y0 <= v_cnt < PIC_Y0+PIC_H.
  - pic_rd_en = in_win. When in_win, pic_x = h_cnt-PIC_X0 and pic_y = v_cnt-PIC_Y0; otherwise both are 0.
- Delay line:
  - raw hs/vs/de, in_win and first-pixel flag are delayed READ_LAT cycles.
  - The output register samples read_data at the same cycle the delayed in_win is high.
  - Total latency from pic_rd_en high to the matching vout_data/de = READ_LAT+1 cycles. hs/vs/de keep identical relative timing.
- Colour:
  - Window pixels, PIX_MODE=0: R={d[15:11],d[15:13]}, G={d[10:5],d[10:9]}, B={d[4:0],d[4:2]}.
  - Window pixels, PIX_MODE=1: read_data passes through.
  - Active pixels outside the window: BORDER_COLOR.
  - Blanking: 24'h0.
- frame_start: high for one cycle with the output pixel whose stage-0 counters were (0,0).
- Reset:
  - Asynchronous; clears counters and the whole delay line.
  - Outputs during reset: de=0, pic_rd_en=0, pic_x=pic_y=0, vout_data=0, frame_start=0, hs=~HS_POL, vs=~VS_POL.
  - After release, counting starts at (0,0).
  - Reset asserted mid-frame truncates the frame. No partial-frame completion.
- Boundaries:
  - A window clipped by the active area (PIC_X0+PIC_W > H_ACTIVE) is clipped, never wrapped.
  - PIC_W or PIC_H = 0 means pic_rd_en is never asserted and all active pixels are border.
  - read_data is ignored whenever the delayed in_win is low.

Test Plan:
Small configuration for all scenarios: H_ACTIVE=8, FP=2, SYNC=2, BP=2 (H_TOTAL=14); V_ACTIVE=4, FP=1, SYNC=1, BP=1 (V_TOTAL=7); window X0=2, Y0=1, W=4, H=2; READ_LAT=2.
- Free run 3 frames -> hs period 14 cycles with active width 2; vs high for 14 cycles per 98; de high 8 per line for 4 lines; frame_start every 98 cycles.
- Buffer model returns read_data = {pic_y,pic_x} exactly 2 cycles after pic_rd_en, PIX_MODE=1 -> rows 1-2, columns 2-5 show the matching values; other active pixels equal BORDER_COLOR; pic_rd_en-to-de latency is 3 cycles.
- PIX_MODE=0 with read_data=16'hF81F -> vout_data=24'hFF00FF; with 16'h07E0 -> 24'h00FF00.
- HS_POL=0, VS_POL=0 -> sync pulses low; during reset hs=vs=1.
- Assert rst_n low at h_cnt=5, v_cnt=2 for 3 cycles -> all outputs are at reset values immediately; after release the first pixel is frame (0,0) and frame_start fires at the first de.
- PIC_X0=6, PIC_W=4 (clipped) -> only columns 6-7 assert pic_rd_en, with pic_x 0-1.
